stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/bcd_digit_en.sv | 46 ++++
 rtl/stopwatch_ctrl.sv | 147 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared state encoding and BCD constants for the stopwatch block.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // Controller state; encoded as plain constants for legacy tool flows
    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Largest legal value of one BCD digit
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Number of BCD digits in the count and on the display
    localparam int NUM_DIGITS = 4;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_digit_en.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_en
// Purpose  : One BCD digit (0..9) with enable in and carry out, so digits
//            can be chained into a multi-digit decimal counter.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_en
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Next digit value: clear wins, otherwise count 0..9 and roll over
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (en) begin
            digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    // Digit register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Carry fires on the same edge this digit rolls 9 -> 0
    assign carry = en && (digit_q == BCD_MAX);
    assign digit = digit_q;

endmodule : bcd_digit_en
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : 4-digit BCD stopwatch with run/pause, lap freeze, sticky
//            overflow and a multiplexed digit scan output.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int SCAN_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic        running,
    output logic        lap_active,
    output logic [15:0] count,
    output logic [15:0] q_disp,
    output logic        overflow,
    output logic [3:0]  digit_sel,
    output logic [3:0]  digit_bcd
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] C_SCAN_LAST  = SW'(SCAN_DIV - 1);

    state_t                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [15:0]           lap_q, lap_d;
    logic                  lap_active_q, lap_active_d;
    logic                  overflow_q, overflow_d;
    logic [SW-1:0]         scan_q, scan_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;

    logic                  w_tick;
    logic [NUM_DIGITS:0]   w_carry;

    assign w_tick     = (state_q == ST_RUN) && (presc_q == C_PRESC_LAST);
    assign w_carry[0] = w_tick;

    // Chained BCD digits; each digit advances on the carry of the one below
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_en u_digit (
            .clk   (clk),
            .rst   (reset),
            .clr   (clear),
            .en    (w_carry[i]),
            .digit (count[4*i +: 4]),
            .carry (w_carry[i+1])
        );
    end

    // Run/pause FSM, prescaler, lap capture and sticky overflow
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        overflow_d   = overflow_q;
        if (clear) begin
            state_d      = ST_IDLE;
            presc_d      = '0;
            lap_d        = '0;
            lap_active_d = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            if (start_stop) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_RUN;
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = ST_IDLE;
                endcase
            end
            if (state_q == ST_RUN) begin
                presc_d = w_tick ? '0 : presc_q + PW'(1);
            end
            // Capture uses the pre-increment count when a tick coincides
            if (lap && (state_q != ST_IDLE)) begin
                if (!lap_active_q) begin
                    lap_d        = count;
                    lap_active_d = 1'b1;
                end else begin
                    lap_active_d = 1'b0;
                end
            end
            if (w_tick && w_carry[NUM_DIGITS]) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Display scan rotation runs in every state and ignores clear
    always_comb begin
        scan_d      = scan_q + SW'(1);
        digit_sel_d = digit_sel_q;
        if (scan_q == C_SCAN_LAST) begin
            scan_d      = '0;
            digit_sel_d = {digit_sel_q[NUM_DIGITS-2:0], digit_sel_q[NUM_DIGITS-1]};
        end
    end

    // Control and scan registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            scan_q       <= '0;
            digit_sel_q  <= NUM_DIGITS'(1);
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
            scan_q       <= scan_d;
            digit_sel_q  <= digit_sel_d;
        end
    end

    // Pick the displayed nibble selected by the one-hot scan
    always_comb begin
        digit_bcd = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel_q[i]) begin
                digit_bcd = q_disp[4*i +: 4];
            end
        end
    end

    assign running    = (state_q == ST_RUN);
    assign lap_active = lap_active_q;
    assign overflow   = overflow_q;
    assign q_disp     = lap_active_q ? lap_q : count;
    assign digit_sel  = digit_sel_q;

endmodule : stopwatch_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Self-checking bench for stopwatch_ctrl against a decimal
//            reference model, with directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic        running;
    logic        lap_active;
    logic [15:0] count;
    logic [15:0] q_disp;
    logic        overflow;
    logic [3:0]  digit_sel;
    logic [3:0]  digit_bcd;

    stopwatch_ctrl #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .running    (running),
        .lap_active (lap_active),
        .count      (count),
        .q_disp     (q_disp),
        .overflow   (overflow),
        .digit_sel  (digit_sel),
        .digit_bcd  (digit_bcd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state, kept as plain decimal numbers
    int m_mode;
    int m_count;
    int m_presc;
    int m_lap;
    int m_scan;
    bit m_lapact;
    bit m_ovf;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_count  = 0;
        m_presc  = 0;
        m_lap    = 0;
        m_scan   = 0;
        m_lapact = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_edge(input bit ss, input bit lp, input bit cl);
        bit tick;
        m_scan++;
        if (cl) begin
            m_mode   = M_IDLE;
            m_count  = 0;
            m_presc  = 0;
            m_lap    = 0;
            m_lapact = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            tick = (m_mode == M_RUN) && (m_presc == TICK_DIV - 1);
            if (lp && m_mode != M_IDLE) begin
                if (!m_lapact) begin
                    m_lap    = m_count;
                    m_lapact = 1'b1;
                end else begin
                    m_lapact = 1'b0;
                end
            end
            if (m_mode == M_RUN) begin
                m_presc = tick ? 0 : m_presc + 1;
                if (tick) begin
                    m_count = m_count + 1;
                    if (m_count == 10000) begin
                        m_count = 0;
                        m_ovf   = 1'b1;
                    end
                end
            end
            if (ss) begin
                m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
            end
        end
    endtask

    task automatic check_all();
        int p10 [4] = '{1, 10, 100, 1000};
        int qd;
        int idx;
        qd  = m_lapact ? m_lap : m_count;
        idx = (m_scan / SCAN_DIV) % 4;
        chk("running",    32'(running),    32'(m_mode == M_RUN));
        chk("lap_active", 32'(lap_active), 32'(m_lapact));
        chk("count",      32'(count),      32'(to_bcd(m_count)));
        chk("q_disp",     32'(q_disp),     32'(to_bcd(qd)));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("digit_sel",  32'(digit_sel),  32'(1 << idx));
        chk("digit_bcd",  32'(digit_bcd),  32'((qd / p10[idx]) % 10));
    endtask

    // One clock cycle with the given pulses, then compare against the model
    task automatic step(input bit ss, input bit lp, input bit cl);
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        @(posedge clk);
        model_edge(ss, lp, cl);
        #1;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        check_all();
    endtask

    // Assert reset between edges, check it acts before any clock, release
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_async_count", 32'(count), 32'h0);
        chk("rst_async_run",   32'(running), 32'h0);
        chk("rst_async_sel",   32'(digit_sel), 32'h1);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    task automatic run_until(input int target, input bit at_tick);
        int n = 0;
        while (!(m_count == target &&
                 (!at_tick || (m_mode == M_RUN && m_presc == TICK_DIV - 1)))
               && n < 60000) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("run_until_bound", 32'(n < 60000), 32'h1);
    endtask

    initial begin
        int saved;
        int n;
        #2;
        apply_reset();

        // Start from idle: first tick after TICK_DIV edges
        step(1'b1, 1'b0, 1'b0);
        chk("start_running", 32'(running), 32'h1);
        repeat (TICK_DIV - 1) step(1'b0, 1'b0, 1'b0);
        chk("pre_tick", 32'(count), 32'h0000);
        step(1'b0, 1'b0, 1'b0);
        chk("first_tick", 32'(count), 32'h0001);
        repeat (2 * TICK_DIV) step(1'b0, 1'b0, 1'b0);
        chk("third_tick", 32'(count), 32'h0003);

        // Lap freeze and release
        run_until(15, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("lap_cap", 32'(q_disp), 32'h0015);
        chk("lap_act", 32'(lap_active), 32'h1);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk("lap_hold", 32'(q_disp), 32'h0015);
        step(1'b0, 1'b1, 1'b0);
        chk("lap_rel", 32'(q_disp), 32'(to_bcd(m_count)));

        // Lap coinciding with a tick captures the pre-increment value
        run_until(19, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("lap_tick_q", 32'(q_disp), 32'h0019);
        chk("lap_tick_cnt", 32'(count), 32'h0020);
        step(1'b0, 1'b1, 1'b0);

        // Pause holds count and prescaler
        run_until(42, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        saved = m_presc;
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk("pause_hold", 32'(count), 32'h0042);
        chk("pause_run", 32'(running), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        n = 0;
        while (count == 16'h0042 && n < 10) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("resume_latency", 32'(n), 32'(TICK_DIV - saved));

        // Multi-digit carry
        run_until(99, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("carry_0100", 32'(count), 32'h0100);

        // Frozen 1234 on the scan output; release with start_stop+lap together
        run_until(1234, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (4 * SCAN_DIV * 2) begin
            step(1'b0, 1'b0, 1'b0);
            case (digit_sel)
                4'b0001: chk("scan_d0", 32'(digit_bcd), 32'd4);
                4'b0010: chk("scan_d1", 32'(digit_bcd), 32'd3);
                4'b0100: chk("scan_d2", 32'(digit_bcd), 32'd2);
                4'b1000: chk("scan_d3", 32'(digit_bcd), 32'd1);
                default: chk("scan_onehot", 32'(digit_sel), 32'h1);
            endcase
        end
        step(1'b1, 1'b1, 1'b0);
        chk("both_run", 32'(running), 32'h1);
        chk("both_lap", 32'(lap_active), 32'h0);

        // Wrap at 9999 sets sticky overflow and keeps counting
        run_until(9999, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_count", 32'(count), 32'h0000);
        chk("wrap_ovf", 32'(overflow), 32'h1);
        repeat (30) step(1'b0, 1'b0, 1'b0);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        chk("after_wrap", 32'(count), 32'h0007);

        // clear beats start_stop
        step(1'b1, 1'b0, 1'b1);
        chk("clr_run", 32'(running), 32'h0);
        chk("clr_count", 32'(count), 32'h0000);
        chk("clr_ovf", 32'(overflow), 32'h0);

        // Random pulses
        repeat (3000) begin
            step($urandom % 8 == 0, $urandom % 10 == 0, $urandom % 200 == 0);
        end

        // Reset mid-run, then wait in idle
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        #2;
        apply_reset();
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk("idle_after_rst", 32'(count), 32'h0000);
        step(1'b1, 1'b0, 1'b0);
        chk("restart", 32'(running), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stopwatch_ctrl
`default_nettype wire
